divider_nr_sv: RTL and testbench

Parametrised successor to the team's iterative non-restoring divider. Adds runtime signed/unsigned mode, a ready/start handshake, and divide-by-zero and signed-overflow flags. Latency depends on the operand: the block iterates only over the significant bits of |dividend|. It is a shared arithmetic unit for the CH5 demo datapaths and sits between the switch/operand registers and the display logic.

---
 rtl/divider_nr_sv.sv | 191 +++++++++++++++++++
 tb/tb_divider_nr_sv.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_nr_sv.sv
// Iterative non-restoring divider with signed/unsigned mode, start/ready handshake,
// divide-by-zero and signed-overflow flags. Iterates only over the significant
// bits of |dividend|, so latency tracks operand magnitude.
module divider_nr_sv #(
  parameter int unsigned BITS = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            signed_mode,
  input  logic [BITS-1:0] dividend,
  input  logic [BITS-1:0] divisor,
  output logic            ready,
  output logic            done,
  output logic [BITS-1:0] quotient,
  output logic [BITS-1:0] remainder,
  output logic            div_by_zero,
  output logic            overflow
);

  localparam int unsigned     CntW   = $clog2(BITS + 1);
  localparam logic [BITS-1:0] MinVal = {1'b1, {(BITS-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StIter,
    StFixRem,
    StSignFix,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [BITS-1:0] a_q, a_d, b_q, b_d;
  logic [BITS-1:0] bmag_q, bmag_d;
  logic [BITS-1:0] q_q, q_d;
  logic [BITS:0]   acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mode_q, mode_d, sq_q, sq_d, sr_q, sr_d;
  logic [BITS-1:0] quot_q, quot_d, rem_q, rem_d;
  logic            dbz_q, dbz_d, ovf_q, ovf_d;

  logic            a_neg, b_neg;
  logic [BITS-1:0] a_mag, b_mag;
  logic [CntW-1:0] n_bits, shamt;
  logic [BITS:0]   b_ext, acc_sh, acc_step;
  logic [BITS-1:0] q_sh;

  // Operand magnitudes and the number of significant bits of |a|.
  // MIN negates to itself, which reads correctly as the unsigned magnitude 2^(BITS-1).
  always_comb begin
    a_neg  = mode_q & a_q[BITS-1];
    b_neg  = mode_q & b_q[BITS-1];
    a_mag  = a_neg ? -a_q : a_q;
    b_mag  = b_neg ? -b_q : b_q;
    n_bits = '0;
    for (int i = 0; i < BITS; i++) begin
      if (a_mag[i]) n_bits = CntW'(i + 1);
    end
    shamt = CntW'(BITS) - n_bits;
  end

  // One non-restoring step: shift {acc,q} left, then add or subtract |b| by the old acc sign.
  // The shifted value may wrap, but the step result always fits in BITS+1 bits.
  always_comb begin
    b_ext    = {1'b0, bmag_q};
    acc_sh   = {acc_q[BITS-1:0], q_q[BITS-1]};
    q_sh     = q_q << 1;
    acc_step = acc_q[BITS] ? acc_sh + b_ext : acc_sh - b_ext;
  end

  // Next-state and datapath updates for the divide sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    bmag_d  = bmag_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = dividend;
          b_d     = divisor;
          mode_d  = signed_mode;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = StPrep;
        end
      end
      StPrep: begin
        bmag_d = b_mag;
        q_d    = a_mag << shamt;
        acc_d  = '0;
        cnt_d  = n_bits;
        sq_d   = a_neg ^ b_neg;
        sr_d   = a_neg;
        if (b_q == '0) begin
          dbz_d   = 1'b1;
          quot_d  = '1;
          rem_d   = a_q;
          state_d = StDone;
        end else if (mode_q && (a_q == MinVal) && (b_q == '1)) begin
          ovf_d   = 1'b1;
          quot_d  = MinVal;
          rem_d   = '0;
          state_d = StDone;
        end else if (n_bits != '0) begin
          state_d = StIter;
        end else begin
          state_d = StFixRem;
        end
      end
      StIter: begin
        acc_d = acc_step;
        q_d   = {q_sh[BITS-1:1], ~acc_step[BITS]};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StFixRem;
      end
      StFixRem: begin
        if (acc_q[BITS]) acc_d = acc_q + b_ext;
        state_d = StSignFix;
      end
      StSignFix: begin
        quot_d  = sq_q ? -q_q : q_q;
        rem_d   = sr_q ? -acc_q[BITS-1:0] : acc_q[BITS-1:0];
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      bmag_q  <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bmag_q  <= bmag_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake and held results.
  always_comb begin
    ready       = (state_q == StIdle);
    done        = (state_q == StDone);
    quotient    = quot_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
    overflow    = ovf_q;
  end

endmodule

// File: tb/tb_divider_nr_sv.sv
// Bench for divider_nr_sv: directed table at BITS=16, handshake/reset sequences,
// and random sweeps at BITS=8 and BITS=32 against an arithmetic reference model.
module tb_divider_nr_sv;

  logic clk;
  logic reset;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic       s8, m8, y8, d8, z8, o8;
  logic [7:0] a8, b8, q8, r8;
  logic        s16, m16, y16, d16, z16, o16;
  logic [15:0] a16, b16, q16, r16;
  logic        s32, m32, y32, d32, z32, o32;
  logic [31:0] a32, b32, q32, r32;

  divider_nr_sv #(.BITS(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(s8), .signed_mode(m8), .dividend(a8), .divisor(b8),
    .ready(y8), .done(d8), .quotient(q8), .remainder(r8), .div_by_zero(z8), .overflow(o8)
  );
  divider_nr_sv #(.BITS(16)) u_dut16 (
    .clk(clk), .reset(reset), .start(s16), .signed_mode(m16), .dividend(a16), .divisor(b16),
    .ready(y16), .done(d16), .quotient(q16), .remainder(r16), .div_by_zero(z16),
    .overflow(o16)
  );
  divider_nr_sv #(.BITS(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(s32), .signed_mode(m32), .dividend(a32), .divisor(b32),
    .ready(y32), .done(d32), .quotient(q32), .remainder(r32), .div_by_zero(z32),
    .overflow(o32)
  );

  typedef struct packed {
    logic        ready;
    logic        done;
    logic        z;
    logic        o;
    logic [31:0] q;
    logic [31:0] r;
  } obs_t;

  typedef struct {
    logic        md;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    logic        o;
    int          lat;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic int width_of(input int sel);
    case (sel)
      0:       return 8;
      1:       return 16;
      default: return 32;
    endcase
  endfunction

  task automatic drive(input int sel, input logic st, input logic md, input logic [31:0] a,
                       input logic [31:0] b);
    case (sel)
      0:       begin s8 = st;  m8 = md;  a8 = a[7:0];   b8 = b[7:0];   end
      1:       begin s16 = st; m16 = md; a16 = a[15:0]; b16 = b[15:0]; end
      default: begin s32 = st; m32 = md; a32 = a;       b32 = b;       end
    endcase
  endtask

  function automatic obs_t observe(input int sel);
    obs_t o;
    case (sel)
      0:       o = '{y8, d8, z8, o8, {24'd0, q8}, {24'd0, r8}};
      1:       o = '{y16, d16, z16, o16, {16'd0, q16}, {16'd0, r16}};
      default: o = '{y32, d32, z32, o32, q32, r32};
    endcase
    return o;
  endfunction

  // Reference: plain integer division with truncation, flags and latency from the operand rules.
  function automatic void model(input int w, input logic md, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] q,
                                output logic [31:0] r, output logic z, output logic o,
                                output int lat);
    logic [31:0] mask, minv;
    longint      sa, sb, absa;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    minv = 32'd1 << (w - 1);
    z = 1'b0;
    o = 1'b0;
    if (b == 32'd0) begin
      z = 1'b1; q = mask; r = a; lat = 2;
      return;
    end
    if (md && a == minv && b == mask) begin
      o = 1'b1; q = minv; r = 32'd0; lat = 2;
      return;
    end
    sa = longint'(a);
    sb = longint'(b);
    if (md && a[w-1]) sa = sa - (longint'(1) << w);
    if (md && b[w-1]) sb = sb - (longint'(1) << w);
    q    = 32'(sa / sb) & mask;
    r    = 32'(sa % sb) & mask;
    absa = (sa < 0) ? -sa : sa;
    lat  = 4;
    while (absa > 0) begin
      lat++;
      absa = absa >> 1;
    end
  endfunction

  task automatic wait_done(input int sel, inout int lat, output obs_t res);
    res = observe(sel);
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      res = observe(sel);
      if (res.done) break;
    end
    check($sformatf("w%0d done pulse seen", width_of(sel)), res.done, 1'b1);
  endtask

  // Issue one operation when ready; lat counts negedges after the accept edge up to done.
  task automatic do_op(input int sel, input logic md, input logic [31:0] a,
                       input logic [31:0] b, output obs_t res, output int lat);
    int   guard;
    obs_t nxt;
    guard = 0;
    res   = observe(sel);
    while (!res.ready && guard < 100) begin
      @(negedge clk);
      guard++;
      res = observe(sel);
    end
    check($sformatf("w%0d ready before start", width_of(sel)), res.ready, 1'b1);
    drive(sel, 1'b1, md, a, b);
    @(posedge clk);
    #1 drive(sel, 1'b0, md, a, b);
    lat = 0;
    wait_done(sel, lat, res);
    @(negedge clk);
    nxt = observe(sel);
    check($sformatf("w%0d done single cycle", width_of(sel)), nxt.done, 1'b0);
  endtask

  task automatic verify(input string tag, input obs_t res, input int lat,
                        input logic [31:0] eq, input logic [31:0] er, input logic ez,
                        input logic eo, input int elat);
    check({tag, " quotient"}, res.q, eq);
    check({tag, " remainder"}, res.r, er);
    check({tag, " div_by_zero"}, res.z, ez);
    check({tag, " overflow"}, res.o, eo);
    check({tag, " latency"}, lat, elat);
  endtask

  task automatic rand_sweep(input int sel, input int count);
    int          w, k, lat, elat;
    logic [31:0] mask, minv, a, b, eq, er;
    logic        md, ez, eo;
    obs_t        res;
    w    = width_of(sel);
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    minv = 32'd1 << (w - 1);
    for (int i = 0; i < count; i++) begin
      md = i[0];
      a  = $urandom & mask;
      b  = $urandom & mask;
      k  = $urandom_range(0, 15);
      case (k)
        0:       b = 32'd0;
        1:       begin a = minv; b = mask; end
        2:       a = minv;
        3:       b = mask;
        4:       a = 32'd0;
        default: begin
          a = a >> $urandom_range(0, w - 1);
          b = b >> $urandom_range(0, w - 1);
        end
      endcase
      model(w, md, a, b, eq, er, ez, eo, elat);
      do_op(sel, md, a, b, res, lat);
      verify($sformatf("rnd%0d #%0d md=%0d %0h/%0h", w, i, md, a, b), res, lat, eq, er, ez, eo,
             elat);
    end
  endtask

  vec_t vecs[14];

  initial begin
    obs_t res;
    int   lat, pulses;

    #50_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t res;
    int   lat, pulses;

    vecs[0]  = '{1'b0, 16'd1000,  16'd7,     16'd142,   16'd6,     1'b0, 1'b0, 14};
    vecs[1]  = '{1'b0, 16'd0,     16'd5,     16'd0,     16'd0,     1'b0, 1'b0, 4};
    vecs[2]  = '{1'b1, 16'hFFF9,  16'h0002,  16'hFFFD,  16'hFFFF,  1'b0, 1'b0, 7};
    vecs[3]  = '{1'b1, 16'h0007,  16'hFFFE,  16'hFFFD,  16'h0001,  1'b0, 1'b0, 7};
    vecs[4]  = '{1'b1, 16'hFFF9,  16'hFFFE,  16'h0003,  16'hFFFF,  1'b0, 1'b0, 7};
    vecs[5]  = '{1'b0, 16'h1234,  16'h0000,  16'hFFFF,  16'h1234,  1'b1, 1'b0, 2};
    vecs[6]  = '{1'b0, 16'd100,   16'd10,    16'd10,    16'd0,     1'b0, 1'b0, 11};
    vecs[7]  = '{1'b1, 16'h1234,  16'h0000,  16'hFFFF,  16'h1234,  1'b1, 1'b0, 2};
    vecs[8]  = '{1'b1, 16'h8000,  16'hFFFF,  16'h8000,  16'h0000,  1'b0, 1'b1, 2};
    vecs[9]  = '{1'b0, 16'h8000,  16'hFFFF,  16'h0000,  16'h8000,  1'b0, 1'b0, 20};
    vecs[10] = '{1'b0, 16'hFFFF,  16'h0001,  16'hFFFF,  16'h0000,  1'b0, 1'b0, 20};
    vecs[11] = '{1'b1, 16'h8000,  16'h0001,  16'h8000,  16'h0000,  1'b0, 1'b0, 20};
    vecs[12] = '{1'b1, 16'h7FFF,  16'h8000,  16'h0000,  16'h7FFF,  1'b0, 1'b0, 19};
    vecs[13] = '{1'b1, 16'hFFFF,  16'h0005,  16'h0000,  16'hFFFF,  1'b0, 1'b0, 5};

    reset = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      res = observe(s);
      check($sformatf("w%0d reset ready", width_of(s)), res.ready, 1'b1);
      check($sformatf("w%0d reset done", width_of(s)), res.done, 1'b0);
      check($sformatf("w%0d reset quotient", width_of(s)), res.q, 32'd0);
      check($sformatf("w%0d reset remainder", width_of(s)), res.r, 32'd0);
      check($sformatf("w%0d reset flags", width_of(s)), {res.z, res.o}, 2'b00);
    end
    @(negedge clk);
    reset = 1'b0;

    // Directed table at BITS=16, issued back to back.
    for (int i = 0; i < 14; i++) begin
      do_op(1, vecs[i].md, {16'd0, vecs[i].a}, {16'd0, vecs[i].b}, res, lat);
      verify($sformatf("vec%0d", i), res, lat, {16'd0, vecs[i].q}, {16'd0, vecs[i].r},
             vecs[i].z, vecs[i].o, vecs[i].lat);
    end

    // Reset five cycles into 0xFFFF/3 discards the operation and clears the held results.
    drive(1, 1'b1, 1'b0, 32'hFFFF, 32'd3);
    @(posedge clk);
    #1 drive(1, 1'b0, 1'b0, 32'hFFFF, 32'd3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    res = observe(1);
    check("midop reset ready", res.ready, 1'b1);
    check("midop reset done", res.done, 1'b0);
    check("midop reset quotient", res.q, 32'd0);
    check("midop reset remainder", res.r, 32'd0);
    check("midop reset flags", {res.z, res.o}, 2'b00);
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      res = observe(1);
      if (res.done) pulses++;
    end
    check("no done after reset", pulses, 0);
    do_op(1, 1'b0, 32'hFFFF, 32'd3, res, lat);
    verify("after reset", res, lat, 32'h5555, 32'd0, 1'b0, 1'b0, 20);

    // start held high while busy, with different operands, is ignored.
    drive(1, 1'b1, 1'b0, 32'd100, 32'd7);
    @(posedge clk);
    #1 drive(1, 1'b1, 1'b0, 32'd5, 32'd1);
    lat = 0;
    repeat (6) begin
      @(negedge clk);
      lat++;
    end
    drive(1, 1'b0, 1'b0, 32'd5, 32'd1);
    wait_done(1, lat, res);
    verify("busy start ignored", res, lat, 32'd14, 32'd2, 1'b0, 1'b0, 11);

    // start raised while done is high; it is accepted in the cycle after done.
    drive(1, 1'b1, 1'b0, 32'd1000, 32'd7);
    @(negedge clk);
    res = observe(1);
    check("ready after done", res.ready, 1'b1);
    check("done dropped", res.done, 1'b0);
    @(posedge clk);
    #1 drive(1, 1'b0, 1'b0, 32'd1000, 32'd7);
    lat = 0;
    wait_done(1, lat, res);
    verify("back to back", res, lat, 32'd142, 32'd6, 1'b0, 1'b0, 14);
    @(negedge clk);

    rand_sweep(0, 1000);
    rand_sweep(2, 600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
